// File: rtl/bcd_sched_pkg.sv
// Shared types and default sizing for the BCD conversion scheduler.
// The FSM state type is kept here so checkers can decode it by name.
package bcd_sched_pkg;

    localparam int NUM_REQ_DEF        = 3;
    localparam int BIN_WIDTH_DEF      = 16;
    localparam int BCD_WIDTH_DEF      = 20;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above pointer,
// wrapping past NUM_REQ-1 back to 0.
module rr_arbiter
    import bcd_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int slot;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        slot        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = int'(pointer) + i;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (!grant_valid && req[slot]) begin
                grant_valid = 1'b1;
                grant[slot] = 1'b1;
                grant_idx   = IDX_W'(slot);
            end
        end
    end

endmodule

// File: rtl/bcd_conversion_scheduler.sv
// Time-shares one binary_to_bcd converter between NUM_REQ requesters,
// with round-robin arbitration and a converter timeout.
module bcd_conversion_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int BIN_WIDTH      = BIN_WIDTH_DEF,
    parameter int BCD_WIDTH      = BCD_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*BIN_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic [BCD_WIDTH-1:0]           bcd_result,
    output logic                           timeout_err,
    output logic                           busy,
    output logic                           conv_start,
    output logic [BIN_WIDTH-1:0]           conv_binary,
    input  logic [BCD_WIDTH-1:0]           conv_bcd,
    input  logic                           conv_done
);

    // Handshake: a requester raises req[i] (level) with its word on slice i
    // and holds it until ack[i]; ack[i] is a one-cycle pulse with
    // bcd_result/timeout_err valid, after which the requester drops req[i].
    // Toward the converter, conv_start pulses once and the operand stays put
    // until the first rising edge of conv_done after that pulse.

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_q;
    logic [CNT_W-1:0]     tmo_cnt;
    logic                 done_q;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;

    logic                 load_op;
    logic                 take_done;
    logic                 take_tmo;
    logic                 done_rise;
    logic                 tmo_hit;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req        (req),
        .pointer    (rr_ptr),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .grant_valid(arb_valid)
    );

    assign done_rise = conv_done && !done_q;
    // The counter is cleared in START, so this fires on the last allowed WAIT cycle.
    assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        take_done  = 1'b0;
        take_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    load_op    = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    take_done  = 1'b1;
                    state_next = DELIVER;
                end else if (tmo_hit) begin
                    take_tmo   = 1'b1;
                    state_next = DELIVER;
                end
            end
            DELIVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= conv_done;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == START) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conv_binary <= '0;
            grant_q     <= '0;
        end else if (load_op) begin
            conv_binary <= req_data[arb_idx*BIN_WIDTH +: BIN_WIDTH];
            grant_q     <= arb_idx;
        end
    end

    // Result registers only change on the WAIT->DELIVER transition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcd_result  <= '0;
            timeout_err <= 1'b0;
        end else if (take_done) begin
            bcd_result  <= conv_bcd;
            timeout_err <= 1'b0;
        end else if (take_tmo) begin
            bcd_result  <= '0;
            timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (state == DELIVER) begin
            if (grant_q == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_q + 1'b1;
            end
        end
    end

    always_comb begin
        ack        = '0;
        busy       = (state != IDLE);
        conv_start = (state == START);
        if (state == DELIVER) begin
            ack[grant_q] = 1'b1;
        end
    end

endmodule

// File: doc/bcd_conversion_scheduler.md
Name: bcd_conversion_scheduler

Overview:
Shares one binary_to_bcd converter between NUM_REQ requesters, e.g. operand A, operand B and the result display path of the calculator.
- Arbitrates pending requests round-robin and captures the chosen requester's binary word.
- Sequences the converter's start/done handshake and returns the BCD result with a one-cycle ack to the granted requester.
- Flags a timeout if the converter never reports done.

Parameters:
NUM_REQ, 3, number of requesters sharing the converter
BIN_WIDTH, 16, binary operand width
BCD_WIDTH, 20, BCD result width (5 digits)
TIMEOUT_CYCLES, 64, maximum WAIT cycles before declaring timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester level request, held until its ack
req_data  in  NUM_REQ*BIN_WIDTH  packed binary words; requester i uses slice [i*BIN_WIDTH +: BIN_WIDTH]
ack  out  NUM_REQ  one-hot, one-cycle pulse: bcd_result/timeout_err valid for that requester
bcd_result  out  BCD_WIDTH  result register, valid with ack, held until next ack
timeout_err  out  1  high together with ack when the conversion timed out
busy  out  1  high in every state except IDLE
conv_start  out  1  converter start, one-cycle pulse
conv_binary  out  BIN_WIDTH  operand to converter, stable from START until return to IDLE
conv_bcd  in  BCD_WIDTH  converter output
conv_done  in  1  converter done (level or pulse)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack=0, bcd_result=0, timeout_err=0, busy=0, conv_start=0, conv_binary=0, rr pointer=0, timeout counter=0, done_q=0.
- Reset asserted mid-conversion aborts it. No ack is issued. After release, arbitration restarts with requester 0 highest.
- States:
  - IDLE: if any req, grant = first requester with req set, searching upward (with wrap) from rr pointer. Latch req_data slice into conv_binary, store grant index, go START.
  - START: conv_start=1 for exactly this cycle, clear timeout counter, go WAIT.
  - WAIT: increment timeout counter each cycle.
    - Rising edge of conv_done (conv_done=1 and done_q=0): latch conv_bcd into bcd_result, timeout_err=0, go DELIVER.
    - Counter reaching TIMEOUT_CYCLES: bcd_result=0, timeout_err=1, go DELIVER.
    - Done edge and timeout in the same cycle: done wins.
  - DELIVER: ack[grant]=1 for one cycle, rr pointer = grant+1 (wrap to 0 after NUM_REQ-1), go IDLE.
- done_q is conv_done registered every cycle. A done already high when WAIT is entered is stale and ignored until it falls and rises again.
- Latency, request sampled in IDLE to ack: 3 cycles + converter latency (done edge cycle to ack = 1 cycle).
- Minimum spacing between grants: 4 cycles. Back-to-back requests are served with no extra idle cycle beyond the IDLE evaluation.
- req dropped after grant: conversion still completes and ack still pulses. req dropped before grant: never served.
- req_data changes after grant have no effect (operand is latched).
- Requester still asserting req in the ack cycle (has not yet seen ack) is not re-granted that cycle. The DELIVER→IDLE pass makes the earliest re-grant the following cycle; requesters must drop req on ack.
- Fairness: with all requesters asserting, grant order is 0,1,2,0,1,2...
- timeout_err and bcd_result hold their value after ack until the next DELIVER.

Decomposition:
- Shared package bcd_sched_pkg: state encoding (IDLE, START, WAIT, DELIVER), default widths, TIMEOUT_CYCLES default.
- One sub-module rr_arbiter (parameter NUM_REQ; inputs req, pointer; output one-hot grant plus binary index), purely combinational.
- FSM, timeout counter and registers stay in the top module.

Test Plan:
- Single request: req=3'b001, req_data[15:0]=16'h7771, converter model done after 17 cycles → one conv_start pulse, conv_binary=16'h7771, ack=3'b001, bcd_result=20'h30577, timeout_err=0.
- All three requesters asserted from reset, data 16'd0, 16'd9999, 16'd65535 → acks in order 001, 010, 100; results 20'h00000, 20'h09999, 20'h65535; busy continuously high between grants except IDLE cycles.
- Converter model never asserts done → ack after exactly TIMEOUT_CYCLES WAIT cycles with timeout_err=1, bcd_result=0; next request then converts normally with timeout_err=0.
- conv_done held high from the previous conversion when START issues → not taken as done; ack only after done falls and rises again.
- reset driven low during WAIT → all outputs return to reset values immediately (asynchronous), no ack. After release, req=3'b110 grants requester 1 first.
- Requester 0 changes req_data and drops req one cycle after grant → conv_binary keeps the original value, ack[0] still pulses with its result.
